// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter / instruction register sequencer alternating FETCH and EXEC; optional halt detection under FETCH_HALT_DETECT_EN
module fetch_sequencer #(
    parameter int PC_WIDTH = 8,
    parameter int RESET_PC = 0
) (
    input  logic                clk,
    input  logic                resetBar,
    input  logic [7:0]          romData,
    input  logic [7:0]          busIn,
    input  logic                doJump,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] romAddr,
    output logic [PC_WIDTH-1:0] pc,
    output logic [7:0]          ir,
    output logic                phase,
    output logic                execEnable,
    output logic                immValid,
    output logic [PC_WIDTH-1:0] instrAddr,
    output logic                halted
);

    localparam logic [PC_WIDTH-1:0] L_RESET_PC = PC_WIDTH'(RESET_PC);
    localparam logic S_FETCH = 1'b0;
    localparam logic S_EXEC  = 1'b1;

    logic                r_phase;
    logic                w_phase_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_instr_addr;
    logic [7:0]          r_ir;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_jump_target;
    logic                w_halted;
    logic                w_frozen;
    logic                w_imm_operand;

    // The jump target is the bus byte resized to the PC width.
    generate
        if (PC_WIDTH == 8) begin : g_tgt_eq
            assign w_jump_target = busIn;
        end else if (PC_WIDTH > 8) begin : g_tgt_wide
            assign w_jump_target = {{(PC_WIDTH-8){1'b0}}, busIn};
        end else begin : g_tgt_narrow
            assign w_jump_target = busIn[PC_WIDTH-1:0];
        end
    endgenerate

    assign w_pc_inc      = r_pc + PC_WIDTH'(1);
    assign w_frozen      = stall | w_halted;
    assign w_imm_operand = (r_ir[2:0] == 3'd0);

`ifdef FETCH_HALT_DETECT_EN
    logic r_halted;
    logic w_halt_set;

    // A jump to the instruction's own address means the program has parked itself.
    assign w_halt_set = (r_phase == S_EXEC) & ~w_frozen & doJump
                        & (w_jump_target == r_instr_addr);

    // Sticky halt flag; only reset clears it.
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            r_halted <= 1'b0;
        end else if (w_halt_set) begin
            r_halted <= 1'b1;
        end
    end

    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

    // Phase state register.
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            r_phase <= S_FETCH;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Next phase: toggle every cycle unless stalled or halted.
    always_comb begin
        w_phase_next = r_phase;
        if (!w_frozen) begin
            case (r_phase)
                S_FETCH: w_phase_next = S_EXEC;
                default: w_phase_next = S_FETCH;
            endcase
        end
    end

    // Next PC: FETCH always steps; EXEC prefers a jump, then skips a consumed immediate.
    always_comb begin
        w_pc_next = r_pc;
        if (r_phase == S_FETCH) begin
            w_pc_next = w_pc_inc;
        end else if (doJump) begin
            w_pc_next = w_jump_target;
        end else if (w_imm_operand) begin
            w_pc_next = w_pc_inc;
        end
    end

    // PC, instruction register and fetch address; all frozen while stalled or halted.
    always_ff @(posedge clk or negedge resetBar) begin
        if (!resetBar) begin
            r_pc         <= L_RESET_PC;
            r_ir         <= 8'h00;
            r_instr_addr <= L_RESET_PC;
        end else if (!w_frozen) begin
            if (r_phase == S_FETCH) begin
                r_ir         <= romData;
                r_instr_addr <= r_pc;
            end
            r_pc <= w_pc_next;
        end
    end

    // Outputs; execEnable gates every architectural side effect in the decoder.
    always_comb begin
        romAddr    = r_pc;
        pc         = r_pc;
        ir         = r_ir;
        phase      = r_phase;
        instrAddr  = r_instr_addr;
        halted     = w_halted;
        execEnable = r_phase & ~stall & ~w_halted;
        immValid   = r_phase & ~stall & ~w_halted & w_imm_operand;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    logic       clk;
    logic       resetBar;
    logic [7:0] romData;
    logic [7:0] busIn;
    logic       doJump;
    logic       stall;
    logic [7:0] romAddr;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       phase;
    logic       execEnable;
    logic       immValid;
    logic [7:0] instrAddr;
    logic       halted;

    logic [7:0] rom [256];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       s;
        logic       j;
        logic [7:0] b;
        logic [7:0] pc;
        logic [7:0] ir;
        logic       ph;
        logic [7:0] ia;
        logic       ee;
        logic       imm;
        logic       hlt;
    } vec_t;

    vec_t tbl [$];
    vec_t exp_q [$];

    fetch_sequencer #(.PC_WIDTH(8), .RESET_PC(0)) dut (
        .clk        (clk),
        .resetBar   (resetBar),
        .romData    (romData),
        .busIn      (busIn),
        .doJump     (doJump),
        .stall      (stall),
        .romAddr    (romAddr),
        .pc         (pc),
        .ir         (ir),
        .phase      (phase),
        .execEnable (execEnable),
        .immValid   (immValid),
        .instrAddr  (instrAddr),
        .halted     (halted)
    );

    assign romData = rom[romAddr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(input logic s, input logic j, input logic [7:0] b,
                                input logic [7:0] epc, input logic [7:0] eir, input logic eph,
                                input logic [7:0] eia, input logic eee, input logic eimm,
                                input logic ehlt);
        vec_t v;
        v.s = s; v.j = j; v.b = b; v.pc = epc; v.ir = eir; v.ph = eph;
        v.ia = eia; v.ee = eee; v.imm = eimm; v.hlt = ehlt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic compare(input string tag, input vec_t e);
        chk({tag, ".pc"},         pc,                 e.pc);
        chk({tag, ".romAddr"},    romAddr,            e.pc);
        chk({tag, ".ir"},         ir,                 e.ir);
        chk({tag, ".phase"},      {7'd0, phase},      {7'd0, e.ph});
        chk({tag, ".instrAddr"},  instrAddr,          e.ia);
        chk({tag, ".execEnable"}, {7'd0, execEnable}, {7'd0, e.ee});
        chk({tag, ".immValid"},   {7'd0, immValid},   {7'd0, e.imm});
        chk({tag, ".halted"},     {7'd0, halted},     {7'd0, e.hlt});
    endtask

    // Called at a falling edge: drive, queue the expectation, clock, then compare.
    task automatic step(input string tag, input vec_t v);
        vec_t e;
        stall  = v.s;
        doJump = v.j;
        busIn  = v.b;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        compare(tag, e);
        @(negedge clk);
    endtask

    task automatic reset_check(input string tag);
        chk({tag, ".pc"},        pc,              8'h00);
        chk({tag, ".ir"},        ir,              8'h00);
        chk({tag, ".instrAddr"}, instrAddr,       8'h00);
        chk({tag, ".phase"},     {7'd0, phase},   8'h00);
        chk({tag, ".halted"},    {7'd0, halted},  8'h00);
        chk({tag, ".execEn"},    {7'd0, execEnable}, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'hFF;
        rom[8'h00] = 8'h12; rom[8'h01] = 8'h25; rom[8'h02] = 8'h01;
        rom[8'h05] = 8'h20; rom[8'h06] = 8'h7A; rom[8'h07] = 8'h03;
        rom[8'h08] = 8'h09; rom[8'h30] = 8'h04; rom[8'h40] = 8'h06;
        rom[8'hFE] = 8'h28; rom[8'hFF] = 8'h01;

        //                s  j  bus    pc     ir     ph ia     ee imm h
        tbl.push_back(mk(0, 0, 8'h00, 8'h01, 8'h12, 1, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h01, 8'h12, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h02, 8'h25, 1, 8'h01, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h02, 8'h25, 0, 8'h01, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h03, 8'h01, 1, 8'h02, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h05, 8'h05, 8'h01, 0, 8'h02, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h06, 8'h20, 1, 8'h05, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h07, 8'h20, 0, 8'h05, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h08, 8'h03, 1, 8'h07, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'h40, 8'h40, 8'h03, 0, 8'h07, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h41, 8'h06, 1, 8'h40, 1, 0, 0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1, 1, 8'h10, 8'h41, 8'h06, 1, 8'h40, 0, 0, 0));
        tbl.push_back(mk(0, 1, 8'h30, 8'h30, 8'h06, 0, 8'h40, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h31, 8'h04, 1, 8'h30, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'hFE, 8'hFE, 8'h04, 0, 8'h30, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 8'hFE, 8'h04, 0, 8'h30, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'hFF, 8'h28, 1, 8'hFE, 1, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 8'h28, 0, 8'hFE, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h01, 8'h12, 1, 8'h00, 1, 0, 0));
        tbl.push_back(mk(0, 1, 8'hFF, 8'hFF, 8'h12, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 8'h01, 1, 8'hFF, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 8'h00, 8'h01, 0, 8'hFF, 0, 0, 0));

        resetBar = 1'b0; stall = 1'b0; doJump = 1'b0; busIn = 8'h00;
        #1;
        reset_check("rst_imm");
        repeat (3) @(posedge clk);
        #1;
        reset_check("rst_held");
        @(negedge clk);
        resetBar = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("vec%0d", i), tbl[i]);

        // Jump-to-self from 0x08.
        step("self_f0", mk(0, 0, 8'h00, 8'h01, 8'h12, 1, 8'h00, 1, 0, 0));
        step("self_j0", mk(0, 1, 8'h08, 8'h08, 8'h12, 0, 8'h00, 0, 0, 0));
        step("self_f1", mk(0, 0, 8'h00, 8'h09, 8'h09, 1, 8'h08, 1, 0, 0));
`ifdef FETCH_HALT_DETECT_EN
        step("self_j1", mk(0, 1, 8'h08, 8'h08, 8'h09, 0, 8'h08, 0, 0, 1));
        for (int i = 0; i < 10; i++)
            step($sformatf("halt%0d", i), mk(0, 0, 8'h00, 8'h08, 8'h09, 0, 8'h08, 0, 0, 1));
`else
        step("self_j1", mk(0, 1, 8'h08, 8'h08, 8'h09, 0, 8'h08, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            step($sformatf("loopf%0d", i), mk(0, 0, 8'h00, 8'h09, 8'h09, 1, 8'h08, 1, 0, 0));
            step($sformatf("loopj%0d", i), mk(0, 1, 8'h08, 8'h08, 8'h09, 0, 8'h08, 0, 0, 0));
        end
`endif
        #2;
        resetBar = 1'b0;
        #1;
        reset_check("rst_after_self");
        @(negedge clk);
        resetBar = 1'b1;

        // Reset asserted in the middle of an EXEC cycle.
        step("mid_f", mk(0, 0, 8'h00, 8'h01, 8'h12, 1, 8'h00, 1, 0, 0));
        doJump = 1'b1; busIn = 8'h55;
        #2;
        resetBar = 1'b0;
        #1;
        reset_check("rst_mid_exec");
        @(negedge clk);
        resetBar = 1'b1;
        step("post_rst_f", mk(0, 0, 8'h00, 8'h01, 8'h12, 1, 8'h00, 1, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
